// File: rtl/spm_dma_pkg.sv
// ============================================================================
// Module   : spm_dma_pkg
// Brief    : Shared types and constants for the scratchpad stream DMA.
// Revision : 1.0
// ============================================================================
`default_nettype none

package spm_dma_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } dma_state_t;

    localparam logic       DIR_READ       = 1'b0;
    localparam logic       DIR_WRITE      = 1'b1;
    localparam int         SPM_WORD_WIDTH = 32;
    localparam logic [3:0] SPM_BE_FULL    = 4'hF;

endpackage

`default_nettype wire

// File: rtl/spm_dma_skid.sv
// ============================================================================
// Module   : spm_dma_skid
// Brief    : 2-entry fall-through valid/ready FIFO for the DMA read path.
// Revision : 1.0
// ============================================================================
`default_nettype none

module spm_dma_skid #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       occupancy
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_rd_ptr;
    logic             r_wr_ptr;
    logic [1:0]       r_count;

    logic w_empty;
    logic w_store;
    logic w_drain;

    // An arriving word bypasses storage when the FIFO is empty and the sink is ready.
    assign w_empty   = (r_count == 2'd0);
    assign w_store   = in_valid && !(w_empty && out_ready);
    assign w_drain   = out_ready && !w_empty;
    assign out_valid = !w_empty || in_valid;
    assign out_data  = !w_empty ? r_mem[r_rd_ptr] : (in_valid ? in_data : '0);
    assign occupancy = r_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_store) begin
                r_mem[r_wr_ptr] <= in_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_drain) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_store} - {1'b0, w_drain};
        end
    end

endmodule

`default_nettype wire

// File: rtl/spm_stream_dma.sv
// ============================================================================
// Module   : spm_stream_dma
// Brief    : Block DMA between the scratchpad port and tx/rx valid/ready streams.
// Revision : 1.0
// ============================================================================
`default_nettype none

module spm_stream_dma
    import spm_dma_pkg::*;
#(
    parameter int ADDR_WIDTH = 11,
    parameter int LEN_WIDTH  = 12
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      direction,
    input  logic [ADDR_WIDTH-1:0]     startAddress,
    input  logic [LEN_WIDTH-1:0]      wordCount,
    output logic                      busy,
    output logic                      done,
    output logic                      spmRequest,
    input  logic                      spmGrant,
    output logic [3:0]                spmByteWe,
    output logic [ADDR_WIDTH-1:0]     spmAddress,
    output logic [SPM_WORD_WIDTH-1:0] spmWriteData,
    input  logic [SPM_WORD_WIDTH-1:0] spmReadData,
    output logic [SPM_WORD_WIDTH-1:0] txData,
    output logic                      txValid,
    input  logic                      txReady,
    input  logic [SPM_WORD_WIDTH-1:0] rxData,
    input  logic                      rxValid,
    output logic                      rxReady
);

    dma_state_t            r_state;
    dma_state_t            w_state_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [LEN_WIDTH-1:0]  r_issue_left;
    logic [LEN_WIDTH-1:0]  r_tx_left;
    logic                  r_inflight;
    logic                  r_done;

    logic       w_accept;
    logic       w_room;
    logic       w_rd_fire;
    logic       w_wr_fire;
    logic       w_tx_fire;
    logic       w_last;
    logic [1:0] w_occ;

    spm_dma_skid #(
        .WIDTH (SPM_WORD_WIDTH)
    ) u_skid (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (r_inflight),
        .in_data   (spmReadData),
        .out_valid (txValid),
        .out_data  (txData),
        .out_ready (txReady),
        .occupancy (w_occ)
    );

    assign w_accept   = (r_state == ST_IDLE) && start;
    // Buffered words plus the read returning this cycle must leave a free slot.
    assign w_room     = ({1'b0, w_occ} + {2'b00, r_inflight}) < 3'd2;
    assign w_tx_fire  = txValid && txReady;
    assign busy       = (r_state != ST_IDLE);
    assign done       = r_done;
    assign spmAddress = r_addr;

    always_comb begin
        w_state_next = r_state;
        spmRequest   = 1'b0;
        spmByteWe    = '0;
        spmWriteData = '0;
        rxReady      = 1'b0;
        w_rd_fire    = 1'b0;
        w_wr_fire    = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && (wordCount != '0)) begin
                    w_state_next = (direction == DIR_WRITE) ? ST_WRITE : ST_READ;
                end
            end
            ST_READ: begin
                spmRequest = (r_issue_left != '0) && w_room;
                w_rd_fire  = spmRequest && spmGrant;
                if (w_tx_fire && (r_tx_left == LEN_WIDTH'(1))) begin
                    w_last       = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            ST_WRITE: begin
                spmRequest = (r_issue_left != '0);
                rxReady    = spmGrant && (r_issue_left != '0);
                w_wr_fire  = rxReady && rxValid;
                if (w_wr_fire) begin
                    spmByteWe    = SPM_BE_FULL;
                    spmWriteData = rxData;
                    if (r_issue_left == LEN_WIDTH'(1)) begin
                        w_last       = 1'b1;
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_addr       <= '0;
            r_issue_left <= '0;
            r_tx_left    <= '0;
            r_inflight   <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_inflight <= w_rd_fire;
            r_done     <= w_last || (w_accept && (wordCount == '0));
            if (w_accept && (wordCount != '0)) begin
                r_addr       <= startAddress;
                r_issue_left <= wordCount;
                r_tx_left    <= wordCount;
            end else begin
                if (w_rd_fire || w_wr_fire) begin
                    r_addr       <= r_addr + ADDR_WIDTH'(1);
                    r_issue_left <= r_issue_left - LEN_WIDTH'(1);
                end
                if (w_tx_fire && (r_state == ST_READ)) begin
                    r_tx_left <= r_tx_left - LEN_WIDTH'(1);
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_spm_stream_dma.sv
// ============================================================================
// Module   : tb_spm_stream_dma
// Brief    : Directed self-checking bench for spm_stream_dma with a scratchpad model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_spm_stream_dma;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        direction;
    logic [10:0] startAddress;
    logic [11:0] wordCount;
    logic        busy;
    logic        done;
    logic        spmRequest;
    logic        spmGrant;
    logic [3:0]  spmByteWe;
    logic [10:0] spmAddress;
    logic [31:0] spmWriteData;
    logic [31:0] spmReadData;
    logic [31:0] txData;
    logic        txValid;
    logic        txReady;
    logic [31:0] rxData;
    logic        rxValid;
    logic        rxReady;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    spm_stream_dma #(
        .ADDR_WIDTH (11),
        .LEN_WIDTH  (12)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .direction    (direction),
        .startAddress (startAddress),
        .wordCount    (wordCount),
        .busy         (busy),
        .done         (done),
        .spmRequest   (spmRequest),
        .spmGrant     (spmGrant),
        .spmByteWe    (spmByteWe),
        .spmAddress   (spmAddress),
        .spmWriteData (spmWriteData),
        .spmReadData  (spmReadData),
        .txData       (txData),
        .txValid      (txValid),
        .txReady      (txReady),
        .rxData       (rxData),
        .rxValid      (rxValid),
        .rxReady      (rxReady)
    );

    // Scratchpad model with a backdoor preload port.
    logic [31:0] mem [0:2047];
    logic        bd_we = 1'b0;
    logic [10:0] bd_addr = '0;
    logic [31:0] bd_data = '0;
    int          access_cnt = 0;

    always @(posedge clock) begin
        if (bd_we) begin
            mem[bd_addr] <= bd_data;
        end else if (spmRequest && spmGrant) begin
            access_cnt <= access_cnt + 1;
            if (spmByteWe != 4'h0) begin
                for (int b = 0; b < 4; b++) begin
                    if (spmByteWe[b]) mem[spmAddress][8*b +: 8] <= spmWriteData[8*b +: 8];
                end
            end else begin
                spmReadData <= mem[spmAddress];
            end
        end
    end

    task automatic preload(input logic [10:0] a, input logic [31:0] d);
        @(posedge clock); #1;
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        @(posedge clock); #1;
        bd_we = 1'b0;
    endtask

    task automatic kick(input logic dir, input logic [10:0] a, input logic [11:0] n);
        @(posedge clock); #1;
        start = 1'b1; direction = dir; startAddress = a; wordCount = n;
    endtask

    task automatic test_reset;
        @(negedge clock);
        n_cmp++;
        if ({busy, done, spmRequest, spmByteWe, spmAddress, spmWriteData, txValid, txData, rxReady} !== '0) begin
            n_err++;
            $display("FAIL reset_values: got busy=%b done=%b req=%b we=%h addr=%h wd=%h txv=%b txd=%h rxr=%b, want all 0",
                     busy, done, spmRequest, spmByteWe, spmAddress, spmWriteData, txValid, txData, rxReady);
        end
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    // 4-word read, then a 1-word read started in the done cycle.
    task automatic test_read_basic;
        logic exp_v, exp_d, exp_b;
        logic [31:0] exp_data;
        for (int i = 0; i < 4; i++) preload(11'h010 + 11'(i), 32'hA0 + 32'(i));
        spmGrant = 1'b1; txReady = 1'b1;
        kick(1'b0, 11'h010, 12'd4);
        for (int c = 1; c <= 9; c++) begin
            @(posedge clock); #1;
            start = (c == 6);
            if (c == 6) begin startAddress = 11'h012; wordCount = 12'd1; end
            @(negedge clock);
            exp_v    = (c >= 2 && c <= 5) || (c == 8);
            exp_data = (c <= 5) ? 32'hA0 + 32'(c - 2) : 32'hA2;
            exp_d    = (c == 6) || (c == 9);
            exp_b    = (c >= 1 && c <= 5) || (c == 7) || (c == 8);
            n_cmp++;
            if (txValid !== exp_v) begin
                n_err++; $display("FAIL rd_txvalid c%0d: got %b want %b", c, txValid, exp_v);
            end
            if (exp_v) begin
                n_cmp++;
                if (txData !== exp_data) begin
                    n_err++; $display("FAIL rd_txdata c%0d: got %h want %h", c, txData, exp_data);
                end
            end
            n_cmp++;
            if ({done, busy} !== {exp_d, exp_b}) begin
                n_err++; $display("FAIL rd_done_busy c%0d: got %b%b want %b%b", c, done, busy, exp_d, exp_b);
            end
        end
    endtask

    task automatic test_write_wrap;
        logic [31:0] wd [3];
        logic [10:0] wa [3];
        wd[0] = 32'h11111111; wd[1] = 32'h22222222; wd[2] = 32'h33333333;
        wa[0] = 11'h7FE; wa[1] = 11'h7FF; wa[2] = 11'h000;
        spmGrant = 1'b1;
        kick(1'b1, 11'h7FE, 12'd3);
        for (int c = 1; c <= 4; c++) begin
            @(posedge clock); #1;
            start = 1'b0;
            rxValid = (c <= 3);
            rxData  = (c <= 3) ? wd[c-1] : 32'h0;
            @(negedge clock);
            if (c <= 3) begin
                n_cmp++;
                if ({rxReady, spmByteWe, spmAddress, spmWriteData} !== {1'b1, 4'hF, wa[c-1], wd[c-1]}) begin
                    n_err++;
                    $display("FAIL wr_beat%0d: got rdy=%b we=%h addr=%h wd=%h want rdy=1 we=f addr=%h wd=%h",
                             c, rxReady, spmByteWe, spmAddress, spmWriteData, wa[c-1], wd[c-1]);
                end
            end else begin
                n_cmp++;
                if ({done, busy, spmByteWe} !== {1'b1, 1'b0, 4'h0}) begin
                    n_err++; $display("FAIL wr_done: got done=%b busy=%b we=%h want 1 0 0", done, busy, spmByteWe);
                end
            end
        end
        rxValid = 1'b0;
        @(posedge clock); #1;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (mem[wa[i]] !== wd[i]) begin
                n_err++; $display("FAIL wr_mem%0d: got %h want %h", i, mem[wa[i]], wd[i]);
            end
        end
    endtask

    task automatic test_backpressure;
        int got = 0;
        int dones = 0;
        logic stall = 1'b0;
        logic [31:0] held = '0;
        for (int i = 0; i < 8; i++) preload(11'h100 + 11'(i), 32'hC0DE0000 + 32'(i));
        kick(1'b0, 11'h100, 12'd8);
        for (int c = 1; c <= 80 && dones == 0; c++) begin
            @(posedge clock); #1;
            start    = 1'b0;
            txReady  = ((c % 4) == 0) || ((c % 4) == 3);
            spmGrant = ((c % 3) != 2);
            @(negedge clock);
            if (stall) begin
                n_cmp++;
                if ({txValid, txData} !== {1'b1, held}) begin
                    n_err++; $display("FAIL bp_stable c%0d: got v=%b d=%h want v=1 d=%h", c, txValid, txData, held);
                end
            end
            if (txValid && txReady) begin
                n_cmp++;
                if (got >= 8 || txData !== 32'hC0DE0000 + 32'(got)) begin
                    n_err++; $display("FAIL bp_word%0d: got %h want %h", got, txData, 32'hC0DE0000 + 32'(got));
                end
                got++;
            end
            stall = txValid && !txReady;
            held  = txData;
            if (done) begin
                dones++;
                n_cmp++;
                if (busy !== 1'b0) begin
                    n_err++; $display("FAIL bp_busy_at_done: got %b want 0", busy);
                end
            end
        end
        n_cmp++;
        if (got !== 8 || dones !== 1) begin
            n_err++; $display("FAIL bp_totals: got words=%0d dones=%0d want 8 and 1", got, dones);
        end
        spmGrant = 1'b1; txReady = 1'b1;
    endtask

    task automatic test_zero_length;
        int acc0;
        acc0 = access_cnt;
        kick(1'b0, 11'h020, 12'd0);
        for (int c = 1; c <= 3; c++) begin
            @(posedge clock); #1;
            start = 1'b0;
            @(negedge clock);
            n_cmp++;
            if ({done, busy, spmRequest} !== {(c == 1), 1'b0, 1'b0}) begin
                n_err++; $display("FAIL zero_len c%0d: got done=%b busy=%b req=%b want %b 0 0", c, done, busy, spmRequest, (c == 1));
            end
        end
        n_cmp++;
        if (access_cnt !== acc0) begin
            n_err++; $display("FAIL zero_len_access: got %0d accesses want 0", access_cnt - acc0);
        end
    endtask

    task automatic test_reset_midway;
        for (int i = 0; i < 2; i++) preload(11'h300 + 11'(i), 32'h5A5A0000 + 32'(i));
        kick(1'b0, 11'h200, 12'd16);
        for (int c = 1; c <= 5; c++) begin
            @(posedge clock); #1;
            start = 1'b0;
        end
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        n_cmp++;
        if ({busy, done, spmRequest, spmByteWe, spmAddress, spmWriteData, txValid, txData, rxReady} !== '0) begin
            n_err++;
            $display("FAIL midreset_values: got busy=%b done=%b req=%b we=%h addr=%h wd=%h txv=%b txd=%h rxr=%b, want all 0",
                     busy, done, spmRequest, spmByteWe, spmAddress, spmWriteData, txValid, txData, rxReady);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            n_cmp++;
            if ({done, busy, txValid} !== 3'b000) begin
                n_err++; $display("FAIL midreset_quiet%0d: got done=%b busy=%b txv=%b want 0 0 0", c, done, busy, txValid);
            end
        end
        kick(1'b0, 11'h300, 12'd2);
        for (int c = 1; c <= 4; c++) begin
            @(posedge clock); #1;
            start = 1'b0;
            @(negedge clock);
            n_cmp++;
            if ({txValid, done} !== {(c == 2 || c == 3), (c == 4)}) begin
                n_err++; $display("FAIL postreset_ctl c%0d: got v=%b done=%b want %b %b", c, txValid, done, (c == 2 || c == 3), (c == 4));
            end
            if (c == 2 || c == 3) begin
                n_cmp++;
                if (txData !== 32'h5A5A0000 + 32'(c - 2)) begin
                    n_err++; $display("FAIL postreset_data c%0d: got %h want %h", c, txData, 32'h5A5A0000 + 32'(c - 2));
                end
            end
        end
    endtask

    task automatic test_start_while_busy;
        kick(1'b0, 11'h010, 12'd4);
        for (int c = 1; c <= 7; c++) begin
            @(posedge clock); #1;
            start = (c == 2);
            if (c == 2) begin
                direction = 1'b1; startAddress = 11'h300; wordCount = 12'd2;
                rxValid = 1'b1; rxData = 32'hDEADBEEF;
            end
            @(negedge clock);
            n_cmp++;
            if ({txValid, done, spmByteWe, rxReady} !== {(c >= 2 && c <= 5), (c == 6), 4'h0, 1'b0}) begin
                n_err++;
                $display("FAIL busy_start c%0d: got v=%b done=%b we=%h rxr=%b want %b %b 0 0",
                         c, txValid, done, spmByteWe, rxReady, (c >= 2 && c <= 5), (c == 6));
            end
            if (c >= 2 && c <= 5) begin
                n_cmp++;
                if (txData !== 32'hA0 + 32'(c - 2)) begin
                    n_err++; $display("FAIL busy_start_data c%0d: got %h want %h", c, txData, 32'hA0 + 32'(c - 2));
                end
            end
        end
        rxValid = 1'b0;
        n_cmp++;
        if (mem[11'h300] !== 32'h5A5A0000) begin
            n_err++; $display("FAIL busy_start_mem: got %h want 5a5a0000", mem[11'h300]);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; direction = 1'b0; startAddress = '0; wordCount = '0;
        spmGrant = 1'b0; txReady = 1'b0; rxData = '0; rxValid = 1'b0;
        @(posedge clock); #1;
        test_reset();
        test_read_basic();
        test_write_wrap();
        test_backpressure();
        test_zero_length();
        test_reset_midway();
        test_start_while_busy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
